// File: rtl/edge_seq_defs.sv
// Shared definitions for the edge-detector frame sequencer.
// Holds the FSM state encoding, counter widths and the default pass timeout.
// Imported by the sequencer RTL and by its testbench.
package edge_seq_defs;

  // One 640x480 pass takes 2764800 cycles; leave some margin.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 3000000;

  localparam int unsigned TIMER_W = 22;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DROP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_START      = 2'd2,
    ST_RUN        = 2'd3
  } state_e;

endpackage

// File: rtl/edge_sequencer.sv
// Edge-detector frame sequencer.
// Ping-pongs the camera capture bank, launches one edge-detector pass per
// captured frame, flips the displayed edge-map bank when a pass completes,
// and tracks completed passes, dropped camera frames and pass timeouts.
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   enable              - level; 1 = keep processing frames
//   frame_done          - pulse: camera finished writing cap_bank
//   ed_done             - pulse: edge-detector pass finished
//   ed_start            - pulse: start an edge-detector pass
//   cap_bank            - bank the camera writes into
//   ed_src_bank         - bank the edge detector reads from
//   disp_bank           - edge-map bank shown on the display
//   busy                - pass in flight (START or RUN)
//   frame_count[15:0]   - completed passes, wraps
//   dropped[7:0]        - camera frames not processed, saturating
//   timeout             - sticky: a pass exceeded TIMEOUT_CYCLES
// TIMEOUT_CYCLES must lie in 1..4194303 (22-bit timer).
module edge_sequencer
  import edge_seq_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_done,
  input  logic        ed_done,
  output logic        ed_start,
  output logic        cap_bank,
  output logic        ed_src_bank,
  output logic        disp_bank,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [7:0]  dropped,
  output logic        timeout
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q,       state_d;
  logic                ed_start_q,    ed_start_d;
  logic                cap_bank_q,    cap_bank_d;
  logic                ed_src_bank_q, ed_src_bank_d;
  logic                disp_bank_q,   disp_bank_d;
  logic                busy_q,        busy_d;
  logic [COUNT_W-1:0]  frame_count_q, frame_count_d;
  logic [DROP_W-1:0]   dropped_q,     dropped_d;
  logic                timeout_q,     timeout_d;
  logic [TIMER_W-1:0]  timer_q,       timer_d;

  always_comb begin
    state_d       = state_q;
    ed_start_d    = 1'b0;
    cap_bank_d    = cap_bank_q;
    ed_src_bank_d = ed_src_bank_q;
    disp_bank_d   = disp_bank_q;
    frame_count_d = frame_count_q;
    dropped_d     = dropped_q;
    timeout_d     = timeout_q;
    timer_d       = timer_q;

    case (state_q)
      ST_IDLE: begin
        // frame_done here is deliberately not counted: nothing was armed.
        if (enable) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (frame_done) begin
          state_d       = ST_START;
          ed_start_d    = 1'b1;
          cap_bank_d    = ~cap_bank_q;
          ed_src_bank_d = cap_bank_q;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        timer_d = timer_q + 1'b1;
        // ed_done takes precedence over expiry in the same cycle.
        if (ed_done) begin
          disp_bank_d   = ~disp_bank_q;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = enable ? ST_WAIT_FRAME : ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = enable ? ST_WAIT_FRAME : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_done && (state_q == ST_START || state_q == ST_RUN)
        && dropped_q != '1) begin
      dropped_d = dropped_q + 1'b1;
    end

    busy_d = (state_d == ST_START) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ed_start_q    <= 1'b0;
      cap_bank_q    <= 1'b0;
      ed_src_bank_q <= 1'b1;
      disp_bank_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      dropped_q     <= '0;
      timeout_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      ed_start_q    <= ed_start_d;
      cap_bank_q    <= cap_bank_d;
      ed_src_bank_q <= ed_src_bank_d;
      disp_bank_q   <= disp_bank_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      dropped_q     <= dropped_d;
      timeout_q     <= timeout_d;
      timer_q       <= timer_d;
    end
  end

  assign ed_start    = ed_start_q;
  assign cap_bank    = cap_bank_q;
  assign ed_src_bank = ed_src_bank_q;
  assign disp_bank   = disp_bank_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;
  assign dropped     = dropped_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_edge_sequencer.sv
// Self-checking bench for edge_sequencer with a 20-cycle pass timeout.
// The reference model tracks an "armed" flag and the age of the pass in
// flight, and derives every expected output from those.
module tb_edge_sequencer;
  import edge_seq_defs::*;

  localparam int unsigned TO = 20;
  localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset, enable, frame_done, ed_done;
  logic        ed_start, cap_bank, ed_src_bank, disp_bank, busy, timeout;
  logic [15:0] frame_count;
  logic [7:0]  dropped;

  edge_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_done(frame_done),
    .ed_done(ed_done), .ed_start(ed_start), .cap_bank(cap_bank),
    .ed_src_bank(ed_src_bank), .disp_bank(disp_bank), .busy(busy),
    .frame_count(frame_count), .dropped(dropped), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: m_age = -1 no pass, 0 launch cycle, k>=1 k-th RUN cycle.
  bit          m_armed, m_start, m_cap, m_src, m_disp, m_to;
  int          m_age = -1;
  int unsigned m_count, m_drop;

  logic [29:0] act_vec;
  assign act_vec = {ed_start, cap_bank, ed_src_bank, disp_bank, busy,
                    frame_count, dropped, timeout};

  localparam logic [29:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0};

  function automatic logic [29:0] model_vec();
    return {m_start, m_cap, m_src, m_disp, (m_age >= 0),
            16'(m_count), 8'(m_drop), m_to};
  endfunction

  task automatic tick(input bit r, input bit e, input bit f, input bit d);
    reset = r; enable = e; frame_done = f; ed_done = d;
    @(posedge clk);
    if (r) begin
      m_armed = 0; m_age = -1; m_start = 0; m_cap = 0; m_src = 1;
      m_disp = 0; m_to = 0; m_count = 0; m_drop = 0;
    end else begin
      m_start = 0;
      if (m_age < 0) begin
        if (!m_armed) m_armed = e;
        else if (!e) m_armed = 0;
        else if (f) begin
          m_src = m_cap; m_cap = !m_cap; m_age = 0; m_start = 1;
        end
      end else begin
        if (f && m_drop < DROP_MAX) m_drop++;
        if (m_age == 0) m_age = 1;
        else if (d) begin
          m_disp = !m_disp; m_count = (m_count + 1) % 65536;
          m_age = -1; m_armed = e;
        end else if (m_age == int'(TO)) begin
          m_to = 1; m_age = -1; m_armed = e;
        end else m_age++;
      end
    end
    #1;
  endtask

  // Reset, arm, and launch a pass; returns one cycle after the launch edge.
  task automatic launch();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 1, 1, 1);
    total++;
    if (act_vec !== RESET_VEC) begin
      bad++; $display("FAIL reset_vec: got %h want %h", act_vec, RESET_VEC);
    end
    total++;
    if (act_vec !== model_vec()) begin
      bad++; $display("FAIL reset_model: got %h want %h", act_vec, model_vec());
    end
  endtask

  task automatic test_basic_pass();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    total++;
    if ({ed_start, cap_bank, ed_src_bank, busy} !== 4'b1101) begin
      bad++; $display("FAIL launch: got start/cap/src/busy=%b want 1101",
                      {ed_start, cap_bank, ed_src_bank, busy});
    end
    tick(0, 1, 0, 0);
    total++;
    if (ed_start !== 1'b0 || act_vec !== model_vec()) begin
      bad++; $display("FAIL start_one_cycle: got %h want %h", act_vec, model_vec());
    end
    for (int i = 0; i < 9; i++) begin
      tick(0, 1, 0, 0);
      total++;
      if (act_vec !== model_vec()) begin
        bad++; $display("FAIL run_hold: got %h want %h", act_vec, model_vec());
      end
    end
    tick(0, 1, 0, 1);
    total++;
    if ({disp_bank, frame_count, busy, timeout} !== {1'b1, 16'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL pass_done: got disp=%b count=%0d busy=%b to=%b want 1 1 0 0",
                      disp_bank, frame_count, busy, timeout);
    end
    // Back in WAIT_FRAME: the next frame launches straight away.
    tick(0, 1, 1, 0);
    total++;
    if (ed_start !== 1'b1 || act_vec !== model_vec()) begin
      bad++; $display("FAIL back_to_back: got %h want %h", act_vec, model_vec());
    end
  endtask

  task automatic test_timeout();
    launch();
    tick(0, 1, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) tick(0, 1, 0, 0);
    total++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_expiry: got to=%b busy=%b want 0 1", timeout, busy);
    end
    tick(0, 1, 0, 0);
    total++;
    if ({timeout, frame_count, disp_bank, busy} !== {1'b1, 16'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL expiry: got to=%b count=%0d disp=%b busy=%b want 1 0 0 0",
                      timeout, frame_count, disp_bank, busy);
    end
    total++;
    if (act_vec !== model_vec()) begin
      bad++; $display("FAIL expiry_model: got %h want %h", act_vec, model_vec());
    end
  endtask

  task automatic test_done_at_expiry();
    launch();
    tick(0, 1, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) tick(0, 1, 0, 0);
    tick(0, 1, 0, 1);
    total++;
    if ({timeout, frame_count, disp_bank} !== {1'b0, 16'd1, 1'b1}) begin
      bad++; $display("FAIL done_wins: got to=%b count=%0d disp=%b want 0 1 1",
                      timeout, frame_count, disp_bank);
    end
  endtask

  task automatic test_drop_saturation();
    int counted = 0;
    int iters   = 0;
    bit was_busy;
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    while (counted < 300 && iters < 3000) begin
      was_busy = (m_age >= 0);
      tick(0, 1, 1, m_age == 12);
      if (was_busy) counted++;
      iters++;
      total++;
      if (act_vec !== model_vec()) begin
        bad++; $display("FAIL drop_step: got %h want %h", act_vec, model_vec());
      end
    end
    total++;
    if (counted < 300) begin
      bad++; $display("FAIL drop_budget: got %0d pulses want 300", counted);
    end
    total++;
    if (dropped !== 8'(DROP_MAX)) begin
      bad++; $display("FAIL drop_sat: got %0d want %0d", dropped, DROP_MAX);
    end
  endtask

  task automatic test_enable_drop();
    logic [7:0] drop_before;
    launch();
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL no_abort: got busy=%b want 1", busy);
    end
    tick(0, 0, 0, 1);
    total++;
    if (frame_count !== 16'd1 || busy !== 1'b0) begin
      bad++; $display("FAIL disabled_done: got count=%0d busy=%b want 1 0", frame_count, busy);
    end
    drop_before = dropped;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      total++;
      if (ed_start !== 1'b0 || dropped !== drop_before) begin
        bad++; $display("FAIL idle_frame: got start=%b drop=%0d want 0 %0d",
                        ed_start, dropped, drop_before);
      end
    end
    // Enable and frame_done together in IDLE: the frame is ignored.
    tick(0, 1, 1, 0);
    total++;
    if (ed_start !== 1'b0 || dropped !== drop_before) begin
      bad++; $display("FAIL idle_enable_frame: got start=%b drop=%0d want 0 %0d",
                      ed_start, dropped, drop_before);
    end
    tick(0, 1, 1, 0);
    total++;
    if (ed_start !== 1'b1 || act_vec !== model_vec()) begin
      bad++; $display("FAIL rearm: got %h want %h", act_vec, model_vec());
    end
  endtask

  task automatic test_reset_mid_run();
    launch();
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 0);
    tick(1, 1, 1, 1);
    total++;
    if (act_vec !== RESET_VEC) begin
      bad++; $display("FAIL reset_mid_run: got %h want %h", act_vec, RESET_VEC);
    end
    tick(0, 0, 0, 1);
    total++;
    if (frame_count !== 16'd0 || disp_bank !== 1'b0 || act_vec !== model_vec()) begin
      bad++; $display("FAIL late_done: got %h want %h", act_vec, model_vec());
    end
  endtask

  task automatic test_random();
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 14) == 0);
      total++;
      if (act_vec !== model_vec()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", i, act_vec, model_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; frame_done = 1'b0; ed_done = 1'b0;
    test_reset();
    test_basic_pass();
    test_timeout();
    test_done_at_expiry();
    test_drop_saturation();
    test_enable_drop();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
